// File: rtl/oai_mac_seq.sv
// Bit-serial MAC sequencer for the 12-bit OAI multiplier: serialises each activation
// LSB-first onto oai_c and shift-accumulates oai_e into a dot-product accumulator.
module oai_mac_seq #(
    parameter int XW   = 8,
    parameter int ACCW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [11:0]     in_w,
    input  logic [XW-1:0]   in_x,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_acc,
    output logic            busy,
    output logic [11:0]     oai_a,
    output logic [11:0]     oai_b,
    output logic            oai_c,
    output logic            oai_d,
    input  logic [11:0]     oai_e
);

    localparam int BW = (XW > 1) ? $clog2(XW) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(XW - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [11:0]     w_reg;
    logic [XW-1:0]   x_reg;
    logic            last_reg;
    logic [BW-1:0]   bit_cnt;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] partial;
    logic            accept;
    logic            release_res;

    // Multiplier output is weight-gated by the current bit; shift it into place.
    assign partial = {{(ACCW-12){1'b0}}, oai_e} << bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        oai_c       = 1'b1;
        accept      = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                oai_c = ~x_reg[bit_cnt];
                if (bit_cnt == LAST_BIT) begin
                    state_next = last_reg ? DONE : IDLE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    release_res = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_reg    <= '0;
            x_reg    <= '0;
            last_reg <= 1'b0;
            bit_cnt  <= '0;
            acc      <= '0;
        end else begin
            if (accept) begin
                w_reg    <= in_w;
                x_reg    <= in_x;
                last_reg <= in_last;
                bit_cnt  <= '0;
            end
            if (state == COMPUTE) begin
                acc     <= acc + partial;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (release_res) begin
                acc <= '0;
            end
        end
    end

    assign out_acc = acc;
    assign oai_a   = ~w_reg;
    assign oai_b   = 12'hFFF;
    assign oai_d   = 1'b1;

endmodule

// File: tb/tb_oai_mac_seq.sv
// Directed bench for oai_mac_seq with a behavioural OAI multiplier on the return path.
module tb_oai_mac_seq;

    localparam int XW   = 8;
    localparam int ACCW = 24;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [11:0]     in_w;
    logic [XW-1:0]   in_x;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [ACCW-1:0] out_acc;
    logic            busy;
    logic [11:0]     oai_a;
    logic [11:0]     oai_b;
    logic            oai_c;
    logic            oai_d;
    logic [11:0]     oai_e;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // OAI multiplier: e = ~(a | c) & b & d per bit, giving w & xbit under the used identity.
    assign oai_e = ~(oai_a | {12{oai_c}}) & oai_b & {12{oai_d}};

    oai_mac_seq #(.XW(XW), .ACCW(ACCW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_w(in_w), .in_x(in_x), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .busy(busy),
        .oai_a(oai_a), .oai_b(oai_b), .oai_c(oai_c), .oai_d(oai_d), .oai_e(oai_e)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accept edge, with bit 0 presented.
    task automatic send(input logic [11:0] w, input logic [XW-1:0] x, input logic last);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("accept_wait", {31'd0, in_ready}, 32'd1);
        in_w     = w;
        in_x     = x;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_w     = 12'hA5A;
        in_x     = 8'h5A;
        in_last  = ~last;
    endtask

    task automatic take_result(input string tag, input logic [ACCW-1:0] exp);
        int n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_acc"}, 32'(out_acc), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_w      = '0;
        in_x      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_acc", 32'(out_acc), 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_oai_a", {20'd0, oai_a}, 32'hFFF);
        check("rst_oai_b", {20'd0, oai_b}, 32'hFFF);
        check("rst_oai_c", {31'd0, oai_c}, 32'd1);
        check("rst_oai_d", {31'd0, oai_d}, 32'd1);
        check("idle_oai_e", {20'd0, oai_e}, 32'd0);

        // Single element 15*3: weight appears on oai_e only in bit cycles 0 and 1.
        send(12'h00F, 8'h03, 1'b1);
        for (int i = 0; i < XW; i++) begin
            check($sformatf("t1_oai_e_bit%0d", i), {20'd0, oai_e}, (i < 2) ? 32'h00F : 32'd0);
            check($sformatf("t1_busy_bit%0d", i), {31'd0, busy}, 32'd1);
            check($sformatf("t1_ready_bit%0d", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("t1_valid_bit%0d", i), {31'd0, out_valid}, 32'd0);
            tick();
        end
        check("t1_valid_at_k8", {31'd0, out_valid}, 32'd1);
        take_result("t1", 24'd45);

        // Three-element dot product with in_ready timing on non-last elements.
        send(12'd1, 8'd1, 1'b0);
        for (int i = 1; i < XW; i++) begin
            tick();
            check($sformatf("t2a_ready_cyc%0d", i), {31'd0, in_ready}, 32'd0);
        end
        tick();
        check("t2a_ready_back", {31'd0, in_ready}, 32'd1);
        check("t2a_no_valid", {31'd0, out_valid}, 32'd0);
        send(12'd2, 8'd3, 1'b0);
        for (int i = 1; i <= XW; i++) tick();
        check("t2b_ready_back", {31'd0, in_ready}, 32'd1);
        check("t2b_no_valid", {31'd0, out_valid}, 32'd0);
        send(12'd4095, 8'd255, 1'b1);
        take_result("t2", 24'd1044232);

        // Zero weight and zero activation: multiplier stays quiet throughout.
        send(12'hFFF, 8'h00, 1'b0);
        for (int i = 0; i < XW; i++) begin
            check($sformatf("t3a_oai_e_bit%0d", i), {20'd0, oai_e}, 32'd0);
            tick();
        end
        send(12'h000, 8'hFF, 1'b1);
        for (int i = 0; i < XW; i++) begin
            check($sformatf("t3b_oai_e_bit%0d", i), {20'd0, oai_e}, 32'd0);
            tick();
        end
        take_result("t3", 24'd0);
        check("t3_idle_oai_c", {31'd0, oai_c}, 32'd1);
        check("t3_idle_oai_d", {31'd0, oai_d}, 32'd1);
        check("t3_idle_oai_e", {20'd0, oai_e}, 32'd0);

        // Backpressure: 0x123*0x45 = 20079 held for 5 cycles, then acc must be cleared.
        send(12'h123, 8'h45, 1'b1);
        for (int i = 1; i <= XW; i++) tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("t4_hold_acc%0d", i), 32'(out_acc), 32'd20079);
            check($sformatf("t4_hold_ready%0d", i), {31'd0, in_ready}, 32'd0);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
        end
        take_result("t4", 24'd20079);
        send(12'd1, 8'd1, 1'b1);
        take_result("t4_after", 24'd1);

        // Wrap: 17 * 1044225 mod 2^24.
        for (int i = 0; i < 17; i++) begin
            send(12'd4095, 8'd255, (i == 16) ? 1'b1 : 1'b0);
        end
        take_result("t5_wrap", 24'd974609);

        // Reset while bit 3 is presented discards the element.
        send(12'hFFF, 8'hFF, 1'b1);
        tick();
        tick();
        tick();
        check("t6_pre_busy", {31'd0, busy}, 32'd1);
        check("t6_pre_oai_c", {31'd0, oai_c}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_in_ready", {31'd0, in_ready}, 32'd1);
        check("t6_oai_c", {31'd0, oai_c}, 32'd1);
        check("t6_oai_a", {20'd0, oai_a}, 32'hFFF);
        check("t6_acc", 32'(out_acc), 32'd0);
        send(12'd2, 8'd5, 1'b1);
        take_result("t6_fresh", 24'd10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
